// File: rtl/debounce_one_shot_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_one_shot_pkg
//  Description : Shared constants for the push-button debouncer: default
//                sample depth and the one-shot FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package debounce_one_shot_pkg;

    // Consecutive equal samples needed before a new button level is accepted.
    localparam int unsigned c_SAMPLES_DEFAULT = 8;

    // One-shot FSM states.
    //   ST_IDLE : button released, waiting for a stable high window
    //   ST_FIRE : single-cycle press pulse
    //   ST_HELD : button pressed, waiting for a stable low window
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_HELD = 2'd2
    } db_state_e;

endpackage : debounce_one_shot_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchronizer bringing an asynchronous single-bit
//                input into the clk_i domain.
//  Ports       : clk_i - destination clock
//                rst_i - asynchronous active-high reset (clears both flops)
//                d_i   - asynchronous input
//                q_o   - synchronized output (two clk_i cycles of latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/debounce_one_shot.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_one_shot
//  Description : Push-button debouncer with one-shot press pulse. The raw
//                button is synchronized, sampled on every rising edge of the
//                slow sampling strobe, and a new level is accepted only after
//                SAMPLES consecutive equal samples.
//  Ports       : clk_in    - system clock (100 MHz)
//                reset     - asynchronous active-high reset
//                slow_clk  - slow square wave used only as a sampling strobe
//                btn_in    - raw, bouncing push-button
//                btn_level - debounced button level (registered)
//                btn_pulse - one clk_in-cycle pulse per accepted press
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_one_shot
    import debounce_one_shot_pkg::*;
#(
    parameter int unsigned SAMPLES = c_SAMPLES_DEFAULT   // must be >= 2
) (
    input  logic clk_in,
    input  logic reset,
    input  logic slow_clk,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_pulse
);

    logic               btn_sync;
    logic               slow_clk_q;
    logic               primed_q;
    logic               sample_en;
    logic [SAMPLES-1:0] shreg_q;
    logic [SAMPLES-1:0] shreg_d;
    logic               all_ones;
    logic               all_zeros;
    db_state_e          state_q;
    logic               btn_pulse_q;
    logic               btn_level_q;

    // ------------------------------------------------------------------
    // Button synchronizer
    // ------------------------------------------------------------------
    sync_2ff u_sync_2ff (
        .clk_i (clk_in),
        .rst_i (reset),
        .d_i   (btn_in),
        .q_o   (btn_sync)
    );

    // ------------------------------------------------------------------
    // Sampling strobe: one clk_in cycle per slow_clk rising edge.
    // slow_clk_q is 0 during reset, so without primed_q a slow_clk that is
    // already high at reset release would look like a rising edge. primed_q
    // blocks the strobe for the first cycle after reset, by which time
    // slow_clk_q holds the real previous level.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            slow_clk_q <= 1'b0;
            primed_q   <= 1'b0;
        end else begin
            slow_clk_q <= slow_clk;
            primed_q   <= 1'b1;
        end
    end

    assign sample_en = slow_clk & ~slow_clk_q & primed_q;

    // ------------------------------------------------------------------
    // Sample history: newest sample enters at bit 0.
    // ------------------------------------------------------------------
    assign shreg_d = sample_en ? {shreg_q[SAMPLES-2:0], btn_sync} : shreg_q;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign all_ones  = &shreg_q;
    assign all_zeros = ~|shreg_q;

    // ------------------------------------------------------------------
    // One-shot FSM. Decisions use the registered history, so a sample
    // arriving in the same cycle is seen on the following cycle rather
    // than lost. Outputs are registered alongside the state so they are
    // valid in the same cycle the state is entered.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            btn_pulse_q <= 1'b0;
            btn_level_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (all_ones) begin
                        state_q     <= ST_FIRE;
                        btn_pulse_q <= 1'b1;
                        btn_level_q <= 1'b1;
                    end else begin
                        state_q     <= ST_IDLE;
                        btn_pulse_q <= 1'b0;
                        btn_level_q <= 1'b0;
                    end
                end
                ST_FIRE: begin
                    state_q     <= ST_HELD;
                    btn_pulse_q <= 1'b0;
                    btn_level_q <= 1'b1;
                end
                ST_HELD: begin
                    btn_pulse_q <= 1'b0;
                    if (all_zeros) begin
                        state_q     <= ST_IDLE;
                        btn_level_q <= 1'b0;
                    end else begin
                        state_q     <= ST_HELD;
                        btn_level_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    btn_pulse_q <= 1'b0;
                    btn_level_q <= 1'b0;
                end
            endcase
        end
    end

    assign btn_pulse = btn_pulse_q;
    assign btn_level = btn_level_q;

endmodule : debounce_one_shot
`default_nettype wire

// File: tb/tb_debounce_one_shot.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debounce_one_shot
//  Description : Self-checking bench for debounce_one_shot. The sampling
//                strobe is generated with a short period so that many press
//                episodes fit in a short run. A reference model tracks runs
//                of consecutive equal samples and predicts btn_level and
//                btn_pulse every clk_in cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_one_shot;
    import debounce_one_shot_pkg::*;

    localparam int SMP = int'(c_SAMPLES_DEFAULT);

    logic clk_in = 1'b0;
    logic reset;
    logic slow_clk;
    logic btn_in;
    logic btn_level;
    logic btn_pulse;

    always #5 clk_in = ~clk_in;

    debounce_one_shot #(.SAMPLES(SMP)) u_dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .slow_clk  (slow_clk),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model state
    int   ones_run, zeros_run;     // consecutive high / low samples
    bit   m_level;                 // accepted level (decision time)
    bit   exp_level, exp_pulse;    // expected outputs this cycle
    int   pend;                    // cycles until a decision becomes visible
    bit   pend_level, pend_rise;
    logic cur_btn, cur_s, cur_rst; // values currently driven
    logic b_r1, b_r2;              // effective button at last two edges
    logic last_s, primed_m, rst_last;
    int   n_dut_pulses = 0;
    int   n_exp_pulses = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        ones_run   = 0;
        zeros_run  = SMP;
        m_level    = 1'b0;
        exp_level  = 1'b0;
        exp_pulse  = 1'b0;
        pend       = 0;
    endtask

    // One clock cycle: check outputs after the edge, then drive the inputs
    // that the next edge will see, updating the model if that edge samples.
    task automatic step(input logic b, input logic s, input logic r);
        bit   smp;
        logic sampled;
        @(posedge clk_in);
        cyc++;
        b_r2     = b_r1;
        b_r1     = cur_rst ? 1'b0 : cur_btn;
        primed_m = !cur_rst;
        last_s   = cur_rst ? 1'b0 : cur_s;
        rst_last = cur_rst;
        #1;
        exp_pulse = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                exp_level = pend_level;
                exp_pulse = pend_rise;
                if (pend_rise) n_exp_pulses++;
            end
        end
        check_val("btn_level", 32'(btn_level), 32'(exp_level));
        check_val("btn_pulse", 32'(btn_pulse), 32'(exp_pulse));
        if (btn_pulse === 1'b1) n_dut_pulses++;

        if (r) model_reset();
        smp     = s && !last_s && primed_m && !r;
        sampled = rst_last ? 1'b0 : b_r2;
        if (smp) begin
            if (sampled) begin
                ones_run++;
                zeros_run = 0;
            end else begin
                zeros_run++;
                ones_run = 0;
            end
            if (ones_run >= SMP && !m_level) begin
                m_level = 1'b1; pend = 2; pend_level = 1'b1; pend_rise = 1'b1;
            end else if (zeros_run >= SMP && m_level) begin
                m_level = 1'b0; pend = 2; pend_level = 1'b0; pend_rise = 1'b0;
            end
        end
        cur_btn = b; cur_s = s; cur_rst = r;
        btn_in = b; slow_clk = s; reset = r;
    endtask

    // n strobe periods of hi cycles high / lo cycles low; button either held
    // at lvl (mode 0) or random every cycle (mode 1).
    task automatic periods(input int n, input int hi, input int lo, input int mode, input logic lvl);
        logic b;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < hi + lo; j++) begin
                b = (mode != 0) ? (($urandom & 1) != 0) : lvl;
                step(b, (j < hi), 1'b0);
            end
        end
    endtask

    int base;

    initial begin
        reset = 1'b0; btn_in = 1'b0; slow_clk = 1'b0;
        cur_btn = 1'b0; cur_s = 1'b0; cur_rst = 1'b0;
        b_r1 = 1'b0; b_r2 = 1'b0; last_s = 1'b0; primed_m = 1'b0; rst_last = 1'b0;
        pend_level = 1'b0; pend_rise = 1'b0;
        model_reset();
        #2;
        reset = 1'b1; cur_rst = 1'b1;
        #1;
        check_val("reset_level", 32'(btn_level), 32'd0);
        check_val("reset_pulse", 32'(btn_pulse), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        periods(2, 8, 8, 0, 1'b0);

        // Clean press
        base = n_dut_pulses;
        periods(20, 8, 8, 0, 1'b1);
        periods(20, 8, 8, 0, 1'b0);
        check_val("clean_pulses", 32'(n_dut_pulses - base), 32'd1);

        // Bounce then stable press
        base = n_dut_pulses;
        periods(1, 8, 8, 0, 1'b1); periods(1, 8, 8, 0, 1'b0);
        periods(1, 8, 8, 0, 1'b1); periods(1, 8, 8, 0, 1'b0);
        periods(20, 8, 8, 0, 1'b1);
        periods(20, 8, 8, 0, 1'b0);
        check_val("bounce_pulses", 32'(n_dut_pulses - base), 32'd1);

        // Glitch shorter than the window
        base = n_dut_pulses;
        periods(5, 8, 8, 0, 1'b1);
        periods(12, 8, 8, 0, 1'b0);
        check_val("glitch_pulses", 32'(n_dut_pulses - base), 32'd0);

        // Repeat presses
        base = n_dut_pulses;
        periods(20, 8, 8, 0, 1'b1); periods(20, 8, 8, 0, 1'b0);
        periods(20, 8, 8, 0, 1'b1); periods(20, 8, 8, 0, 1'b0);
        check_val("repeat_pulses", 32'(n_dut_pulses - base), 32'd2);

        // Reset while held
        base = n_dut_pulses;
        periods(12, 8, 8, 0, 1'b1);
        check_val("held_level", 32'(btn_level), 32'd1);
        step(1'b1, 1'b0, 1'b1);
        #1;
        check_val("rst_async_level", 32'(btn_level), 32'd0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        check_val("pre_rst_pulses", 32'(n_dut_pulses - base), 32'd1);
        base = n_dut_pulses;
        periods(7, 8, 8, 0, 1'b1);
        check_val("post_rst_early", 32'(n_dut_pulses - base), 32'd0);
        periods(5, 8, 8, 0, 1'b1);
        periods(20, 8, 8, 0, 1'b0);
        check_val("post_rst_pulses", 32'(n_dut_pulses - base), 32'd1);

        // Static strobe
        base = n_dut_pulses;
        for (int i = 0; i < 800; i++) step(1'b1, 1'b1, 1'b0);
        check_val("static_level", 32'(btn_level), 32'd0);
        check_val("static_pulses", 32'(n_dut_pulses - base), 32'd0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);
        periods(10, 8, 8, 0, 1'b0);

        // Reset released while slow_clk is high
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0);
        base = n_dut_pulses;
        periods(10, 8, 8, 0, 1'b1);
        periods(20, 8, 8, 0, 1'b0);
        check_val("rel_high_pulses", 32'(n_dut_pulses - base), 32'd1);

        // Randomized segments
        for (int seg = 0; seg < 500; seg++) begin
            int   kind, hi, lo, n;
            logic lvl;
            kind = int'($urandom_range(0, 9));
            hi   = int'($urandom_range(1, 6));
            lo   = int'($urandom_range(1, 6));
            lvl  = (($urandom & 1) != 0);
            case (kind)
                0, 1, 2, 3: begin
                    n = int'($urandom_range(1, 14));
                    periods(n, hi, lo, 0, lvl);
                end
                4, 5, 6: begin
                    n = int'($urandom_range(1, 4));
                    periods(n, hi, lo, 1, 1'b0);
                end
                7: begin
                    n = int'($urandom_range(10, 60));
                    for (int i = 0; i < n; i++) step(lvl, cur_s, 1'b0);
                end
                8: begin
                    n = int'($urandom_range(8, 12));
                    periods(n, hi, lo, 0, lvl);
                end
                default: begin
                    if ($urandom_range(0, 3) == 0) begin
                        n = int'($urandom_range(1, 3));
                        for (int i = 0; i < n; i++) step(lvl, (($urandom & 1) != 0), 1'b1);
                    end else begin
                        periods(3, hi, lo, 0, lvl);
                    end
                end
            endcase
        end
        periods(12, 4, 4, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        check_val("pulse_total", 32'(n_dut_pulses), 32'(n_exp_pulses));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_debounce_one_shot
`default_nettype wire

// File: doc/debounce_one_shot.md
DEBOUNCE_ONE_SHOT -- requirements
Module: debounce_one_shot

Interface
REQ-001 SHALL have parameter SAMPLES, default 8: consecutive equal samples required to accept a new button level.
REQ-002 SHALL have port clk_in  input  1  system clock, 100 MHz.
REQ-003 SHALL have port reset  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port slow_clk  input  1  500 Hz square wave produced from clk_in by the team's clock divider; used only as a sampling strobe, never as a clock.
REQ-005 SHALL have port btn_in  input  1  raw push-button; asynchronous and bouncing.
REQ-006 SHALL have port btn_level  output  1  debounced button level.
REQ-007 SHALL have port btn_pulse  output  1  single clk_in-cycle pulse on each accepted press.

Function
REQ-008 SHALL pass btn_in through a two-flop synchronizer clocked by clk_in before any other use.
REQ-009 SHALL register slow_clk once and form sample_en = slow_clk AND NOT slow_clk_q; sample_en is high for exactly one clk_in cycle per slow_clk rising edge, i.e. every 2 ms.
REQ-010 SHALL hold a SAMPLES-bit shift register that shifts in the synchronized button on each sample_en cycle only, and holds otherwise.
REQ-011 SHALL implement FSM states IDLE, FIRE and HELD.
REQ-012 IDLE SHALL transition to FIRE when the shift register is all ones; otherwise it SHALL stay in IDLE.
REQ-013 FIRE SHALL last exactly one clk_in cycle and SHALL always transition to HELD.
REQ-014 HELD SHALL transition to IDLE when the shift register is all zeros; otherwise it SHALL stay in HELD.
REQ-015 btn_pulse SHALL be registered and high only while the state is FIRE.
REQ-016 btn_level SHALL be registered and high while the state is FIRE or HELD.
REQ-017 Latency: btn_pulse SHALL rise two clk_in cycles after the sample_en cycle that completes the all-ones pattern.
REQ-018 Any mixed shift-register pattern (bounce) SHALL cause no state change.
REQ-019 Exactly one btn_pulse SHALL be produced per IDLE-to-HELD episode, regardless of how long the button is held.
REQ-020 A new pulse SHALL require passing through IDLE, i.e. SAMPLES consecutive low samples followed by SAMPLES consecutive high samples.
REQ-021 If slow_clk is static, no sampling SHALL occur and the state SHALL hold.
REQ-022 If sample_en coincides with the FSM transition cycle, the FSM SHALL use the pre-shift register value; no sample SHALL be lost.

Reset
REQ-023 While reset is high, synchronizer flops, slow_clk_q and the shift register SHALL be 0, the state SHALL be IDLE, and btn_level = btn_pulse = 0.
REQ-024 Reset asserted mid-FIRE or mid-HELD SHALL abort immediately with no residual pulse.
REQ-025 After reset, a held button SHALL produce a pulse only after SAMPLES fresh high samples.
REQ-026 Deassertion of reset SHALL cause no spurious sample_en, even if slow_clk is high at that time.

Structure
REQ-027 FSM state encodings and the default SAMPLES value SHALL live in the shared project constants package.
REQ-028 The two-flop synchronizer SHALL be a reusable sub-module named sync_2ff; all other logic SHALL be inline.

Verification
REQ-029 Clean press: btn_in high for 20 ms -> exactly one btn_pulse, rising 2 cycles after the 8th sample_en (about 16 ms); btn_level high until release is debounced.
REQ-030 Bounce: btn_in toggles 5 times within the first 6 ms, then stays high for 20 ms -> exactly one btn_pulse, with btn_level rising only after 8 clean high samples.
REQ-031 Glitch: btn_in high for 10 ms (5 samples), then low -> no btn_pulse, btn_level stays 0.
REQ-032 Repeat: press 20 ms, release 20 ms, press 20 ms -> exactly two btn_pulse; btn_level drops about 16 ms after release.
REQ-033 Reset mid-HELD: assert reset for 3 cycles with btn_in held high -> outputs 0 immediately; next btn_pulse 8 samples after reset deasserts, and none earlier.
REQ-034 Static strobe: slow_clk held at 1 and btn_in held high for 50 ms -> no btn_pulse, state remains IDLE.
